// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its program memory / datapath.
// The master side is the sequencer; the slave side is the memory, PC and datapath.
interface fetch_sequencer_if;
   logic [15:0] instr_in;
   logic [4:0]  flags;
   logic        exec_done;
   logic        mem_re;
   logic        pc_run;
   logic        pc_enable;
   logic [7:0]  pc_increase;
   logic [15:0] ir_out;
   logic        ir_valid;
   logic        halted;

   modport master (
      input  instr_in, flags, exec_done,
      output mem_re, pc_run, pc_enable, pc_increase, ir_out, ir_valid, halted
   );

   modport slave (
      output instr_in, flags, exec_done,
      input  mem_re, pc_run, pc_enable, pc_increase, ir_out, ir_valid, halted
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Moore instruction sequencer: fetch, latch, execute, advance the program counter.
// Every output is a register loaded from the next-state decode.
module fetch_sequencer (
   input  logic              Clock,
   input  logic              Reset,
   fetch_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_LATCH,
      S_EXEC,
      S_ADVANCE,
      S_HALT
   } state_e;

   localparam logic [3:0] OPC_BRANCH = 4'b1100;
   localparam logic [7:0] STEP_ONE   = 8'h01;

   state_e      state_q, state_d;
   logic        mem_re_q, mem_re_d;
   logic        pc_enable_q, pc_enable_d;
   logic [7:0]  pc_increase_q, pc_increase_d;
   logic [15:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic        halted_q, halted_d;
   logic        pc_run_q;

   logic        is_branch;
   logic        taken;
   logic [7:0]  step;

   // flags packing is {N,Z,F,L,C}
   function automatic logic cond_met(input logic [3:0] cc, input logic [4:0] f);
      logic n, z, fl, l, c;
      {n, z, fl, l, c} = f;
      case (cc)
         4'h0:    cond_met = z;
         4'h1:    cond_met = !z;
         4'h2:    cond_met = c;
         4'h3:    cond_met = !c;
         4'h4:    cond_met = l;
         4'h5:    cond_met = !l;
         4'h6:    cond_met = n;
         4'h7:    cond_met = !n;
         4'h8:    cond_met = fl;
         4'h9:    cond_met = !fl;
         4'hA:    cond_met = !l && !z;
         4'hB:    cond_met = l || z;
         4'hC:    cond_met = !n && !z;
         4'hD:    cond_met = n || z;
         4'hE:    cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   endfunction

   assign is_branch = (ir_q[15:12] == OPC_BRANCH);
   assign taken     = is_branch && cond_met(ir_q[11:8], bus.flags);
   assign step      = taken ? ir_q[7:0] : STEP_ONE;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d = state_q;
      ir_d    = ir_q;

      case (state_q)
         // mem_re_q low in FETCH only on the first cycle out of reset: issue the read next cycle
         S_FETCH:   if (mem_re_q) state_d = S_LATCH;
         S_LATCH: begin
            state_d = S_EXEC;
            ir_d    = bus.instr_in;
         end
         S_EXEC: begin
            if (is_branch) begin
               state_d = (taken && (ir_q[7:0] == 8'h00)) ? S_HALT : S_ADVANCE;
            end else if (bus.exec_done) begin
               state_d = S_ADVANCE;
            end
         end
         S_ADVANCE: state_d = S_FETCH;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_FETCH;
      endcase

      mem_re_d      = (state_d == S_FETCH);
      ir_valid_d    = (state_d == S_EXEC);
      pc_enable_d   = (state_d == S_ADVANCE);
      pc_increase_d = (state_d == S_ADVANCE) ? step : 8'h00;
      halted_d      = (state_d == S_HALT);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q       <= S_FETCH;
         mem_re_q      <= 1'b0;
         pc_enable_q   <= 1'b0;
         pc_increase_q <= 8'h00;
         ir_q          <= 16'h0000;
         ir_valid_q    <= 1'b0;
         halted_q      <= 1'b0;
         pc_run_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         mem_re_q      <= mem_re_d;
         pc_enable_q   <= pc_enable_d;
         pc_increase_q <= pc_increase_d;
         ir_q          <= ir_d;
         ir_valid_q    <= ir_valid_d;
         halted_q      <= halted_d;
         pc_run_q      <= 1'b1;
      end
   end

   assign bus.mem_re      = mem_re_q;
   assign bus.pc_run      = pc_run_q;
   assign bus.pc_enable   = pc_enable_q;
   assign bus.pc_increase = pc_increase_q;
   assign bus.ir_out      = ir_q;
   assign bus.ir_valid    = ir_valid_q;
   assign bus.halted      = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a program counter and synchronous memory around it.
// Cycle 0 is the first cycle with mem_re=1 after Reset deasserts.
module tb_fetch_sequencer;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [11:0] pc;
   logic [15:0] mem [0:4095];
   int          total = 0;
   int          bad   = 0;

   fetch_sequencer_if bus ();

   fetch_sequencer dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   // program counter: pc_run low clears, enable adds the sign-extended step
   always @(posedge Clock) begin
      if (!bus.pc_run) pc <= 12'h000;
      else if (bus.pc_enable) pc <= pc + {{4{bus.pc_increase[7]}}, bus.pc_increase};
   end

   always @(posedge Clock) begin
      if (bus.mem_re) bus.instr_in <= mem[pc];
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   endtask

   // leaves the bench at cycle 0 (first FETCH)
   task automatic restart(input int n);
      Reset = 1'b1;
      tick(n);
      Reset = 1'b0;
      tick(1);
   endtask

   logic [15:0] exp_mask;
   logic [4:0]  flag_set;
   int          pulses;

   initial begin
      clear_mem();
      bus.flags     = 5'b00000;
      bus.exec_done = 1'b1;

      // reset state, then the basic 4-cycle period
      Reset = 1'b1;
      tick(2);
      Reset = 1'b0;
      check("rst_mem_re",   16'(bus.mem_re),      16'h0);
      check("rst_pc_run",   16'(bus.pc_run),      16'h0);
      check("rst_pc_en",    16'(bus.pc_enable),   16'h0);
      check("rst_inc",      16'(bus.pc_increase), 16'h00);
      check("rst_ir",       bus.ir_out,           16'h0000);
      check("rst_ir_valid", 16'(bus.ir_valid),    16'h0);
      check("rst_halted",   16'(bus.halted),      16'h0);
      tick(1);
      check("c0_mem_re",   16'(bus.mem_re),   16'h1);
      check("c0_pc_run",   16'(bus.pc_run),   16'h1);
      check("c0_pc",       16'(pc),           16'h000);
      tick(1);
      check("c1_mem_re",   16'(bus.mem_re),   16'h0);
      check("c1_ir_valid", 16'(bus.ir_valid), 16'h0);
      tick(1);
      check("c2_ir_valid", 16'(bus.ir_valid), 16'h1);
      check("c2_pc_en",    16'(bus.pc_enable), 16'h0);
      tick(1);
      check("c3_pc_en",    16'(bus.pc_enable),   16'h1);
      check("c3_inc",      16'(bus.pc_increase), 16'h01);
      check("c3_ir_valid", 16'(bus.ir_valid),    16'h0);
      tick(1);
      check("c4_mem_re",   16'(bus.mem_re),    16'h1);
      check("c4_pc_en",    16'(bus.pc_enable), 16'h0);
      check("c4_inc",      16'(bus.pc_increase), 16'h00);
      check("c4_pc",       16'(pc),            16'h001);

      // EQ branch at address 2, taken and not taken
      mem[2] = 16'hC0FC;
      bus.flags = 5'b01000;
      restart(1);
      tick(10);
      check("eq_t_ir",   bus.ir_out, 16'hC0FC);
      tick(1);
      check("eq_t_en",   16'(bus.pc_enable),   16'h1);
      check("eq_t_inc",  16'(bus.pc_increase), 16'hFC);
      tick(1);
      check("eq_t_pc",   16'(pc), 16'hFFE);
      bus.flags = 5'b00000;
      restart(1);
      tick(11);
      check("eq_n_inc",  16'(bus.pc_increase), 16'h01);
      tick(1);
      check("eq_n_pc",   16'(pc), 16'h003);

      // non-branch stalled by exec_done
      clear_mem();
      mem[0] = 16'h1234;
      bus.exec_done = 1'b0;
      restart(1);
      tick(2);
      check("stall_ir", bus.ir_out, 16'h1234);
      for (int i = 0; i < 5; i++) begin
         check("stall_pc_en",    16'(bus.pc_enable), 16'h0);
         check("stall_ir_valid", 16'(bus.ir_valid),  16'h1);
         if (i < 4) tick(1);
      end
      bus.exec_done = 1'b1;
      tick(1);
      bus.exec_done = 1'b0;
      check("stall_adv_en", 16'(bus.pc_enable), 16'h1);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         if (bus.pc_enable) pulses++;
      end
      check("stall_pulses", 16'(pulses), 16'h0);

      // unconditional branch to self halts until Reset
      mem[0] = 16'hCE00;
      restart(1);
      tick(3);
      check("halt_mem_re", 16'(bus.mem_re), 16'h0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         check("halt_hold", 16'(bus.halted), 16'h1);
         if (bus.pc_enable) pulses++;
         tick(1);
      end
      check("halt_pulses", 16'(pulses), 16'h0);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      check("halt_rst_halted", 16'(bus.halted), 16'h0);
      tick(1);
      check("halt_rst_fetch", 16'(bus.mem_re), 16'h1);

      // never, LO taken, not-taken zero displacement
      clear_mem();
      mem[0] = 16'hCF10;
      mem[1] = 16'hCA05;
      mem[6] = 16'hC000;
      bus.flags     = 5'b00000;
      bus.exec_done = 1'b1;
      restart(1);
      tick(3);
      check("never_inc", 16'(bus.pc_increase), 16'h01);
      tick(4);
      check("lo_inc",    16'(bus.pc_increase), 16'h05);
      tick(1);
      check("lo_pc",     16'(pc), 16'h006);
      tick(3);
      check("z0_inc",    16'(bus.pc_increase), 16'h01);
      check("z0_halted", 16'(bus.halted),      16'h0);
      tick(1);
      check("z0_pc",     16'(pc), 16'h007);

      // every condition code against two flag patterns
      for (int p = 0; p < 2; p++) begin
         flag_set = (p == 0) ? 5'b10100 : 5'b01011;
         exp_mask = (p == 0) ? 16'h656A : 16'h6A95;
         for (int cc = 0; cc < 16; cc++) begin
            mem[0] = {4'hC, 4'(cc), 8'h03};
            bus.flags = flag_set;
            restart(1);
            tick(3);
            check($sformatf("cc%0d_p%0d", cc, p), 16'(bus.pc_increase),
                  exp_mask[cc] ? 16'h03 : 16'h01);
         end
      end

      // Reset pulse mid-EXEC abandons the instruction
      clear_mem();
      mem[1] = 16'h1234;
      bus.flags     = 5'b00000;
      bus.exec_done = 1'b1;
      restart(1);
      tick(4);
      bus.exec_done = 1'b0;
      tick(3);
      check("mid_ir_valid", 16'(bus.ir_valid), 16'h1);
      check("mid_pc",       16'(pc),           16'h001);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      check("mid_ir_valid0", 16'(bus.ir_valid),  16'h0);
      check("mid_pc_run",    16'(bus.pc_run),    16'h0);
      check("mid_pc_en",     16'(bus.pc_enable), 16'h0);
      check("mid_ir0",       bus.ir_out,         16'h0000);
      check("mid_mem_re",    16'(bus.mem_re),    16'h0);
      tick(1);
      check("mid_refetch",   16'(bus.mem_re),    16'h1);
      check("mid_pc_en2",    16'(bus.pc_enable), 16'h0);
      check("mid_pc0",       16'(pc),            16'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have exactly one clock, Clock: input, 1 bit, rising-edge.
REQ-002 The block SHALL have Reset: input, 1 bit, synchronous, active-high.
REQ-003 The block SHALL have instr_in: input, 16 bits, instruction word from synchronous program memory, valid one cycle after mem_re.
REQ-004 The block SHALL have flags: input, 5 bits, {N,Z,F,L,C} from the datapath flag register, stable while in EXEC.
REQ-005 The block SHALL have exec_done: input, 1 bit, datapath completion of a non-branch instruction.
REQ-006 The block SHALL have mem_re: output, 1 bit, program memory read strobe; address is the program counter's program_no.
REQ-007 The block SHALL have pc_run: output, 1 bit, drives the program counter Reset pin; 0 clears program_no, 1 allows it to run.
REQ-008 The block SHALL have pc_enable: output, 1 bit, drives the program counter Enable pin.
REQ-009 The block SHALL have pc_increase: output, 8 bits, signed step for the program counter.
REQ-010 The block SHALL have ir_out: output, 16 bits, latched instruction.
REQ-011 The block SHALL have ir_valid: output, 1 bit, ir_out is valid for the datapath.
REQ-012 The block SHALL have halted: output, 1 bit, sequencer stopped.

Function
REQ-013 The block SHALL implement a Moore FSM with states FETCH, LATCH, EXEC, ADVANCE and HALT; all outputs SHALL be registered.
REQ-014 FETCH SHALL last 1 cycle with mem_re=1, then go to LATCH.
REQ-015 LATCH SHALL last 1 cycle, load ir_out<=instr_in, then go to EXEC.
REQ-016 In EXEC, ir_valid SHALL be 1.
REQ-017 In EXEC, a branch (ir_out[15:12]=4'b1100) SHALL go to ADVANCE after 1 cycle and ignore exec_done.
REQ-018 In EXEC, a non-branch SHALL stay until exec_done=1, then go to ADVANCE.
REQ-019 ADVANCE SHALL last exactly 1 cycle with pc_enable=1, then go to FETCH.
REQ-020 pc_enable SHALL be 0 in every state except ADVANCE, because the program counter adds on every enabled edge.
REQ-021 pc_increase SHALL be valid whenever pc_enable=1, and 8'h00 otherwise.
REQ-022 For a non-branch or a not-taken branch, pc_increase SHALL be 8'h01.
REQ-023 For a taken branch, pc_increase SHALL be ir_out[7:0] unmodified; the program counter sign-extends it to 12 bits, and wrap-around is modulo 4096.
REQ-024 The branch condition field SHALL be ir_out[11:8], evaluated from flags during EXEC as:
- 0 EQ Z
- 1 NE !Z
- 2 CS C
- 3 CC !C
- 4 HI L
- 5 LS !L
- 6 GT N
- 7 LE !N
- 8 FS F
- 9 FC !F
- A LO !L&!Z
- B HS L|Z
- C LT !N&!Z
- D GE N|Z
- E UC 1
- F never 0
REQ-025 A taken branch with displacement 8'h00 SHALL go from EXEC to HALT: halted=1, pc_enable=0, mem_re=0; HALT SHALL exit only on Reset.
REQ-026 A not-taken branch with displacement 8'h00 SHALL advance by 8'h01.
REQ-027 Minimum instruction period SHALL be 4 cycles, measured from FETCH to the next FETCH.

Reset
REQ-028 While Reset=1, at each edge the block SHALL set state=FETCH, pc_run=0, pc_enable=0, pc_increase=8'h00, ir_out=16'h0000, ir_valid=0, mem_re=0, halted=0.
REQ-029 pc_run SHALL be registered from !Reset, so program_no is 0 in the first FETCH after Reset deasserts.
REQ-030 Reset asserted in any state, including mid-EXEC or HALT, SHALL abandon the instruction with no pc_enable pulse.

Verification
REQ-031 Reset 2 cycles, instr_in=16'h0000, exec_done=1 -> mem_re at cycle 0, ir_valid at cycle 2, pc_enable=1 with pc_increase=8'h01 at cycle 3, FETCH again at cycle 4.
REQ-032 instr_in=16'hC0FC (EQ, disp -4) -> with flags Z=1, pc_increase=8'hFC; with Z=0, pc_increase=8'h01; a bench PC at 12'h002 goes to 12'hFFE and 12'h003 respectively.
REQ-033 Non-branch with exec_done held 0 for 5 EXEC cycles -> pc_enable=0 throughout, ir_valid=1; exactly one pc_enable pulse on the cycle after exec_done=1.
REQ-034 instr_in=16'hCE00 (UC, disp 0) -> halted=1, pc_enable never asserted over 20 cycles; Reset returns to FETCH with halted=0.
REQ-035 instr_in=16'hCF10 (never) -> pc_increase=8'h01; instr_in=16'hCA05 with L=0, Z=0 -> pc_increase=8'h05.
REQ-036 Reset pulsed for 1 cycle during EXEC -> next cycle: state FETCH, ir_valid=0, pc_run=0, no pc_enable pulse; PC restarts at 12'h000.
